// File: rtl/vx_mem_req_sched.sv
// vx_mem_req_sched: two-requester (icache=0, dcache=1) memory request scheduler.
// Round-robin arbitration onto a single memory request port with a grant lock
// that holds the current requester while memory back-pressures. Reads are
// tracked per requester (bounded by MAX_PENDING); responses are routed back by
// the LSB of the memory tag.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req{0,1}_*                   requester request channels (valid/ready)
//   rsp{0,1}_*                   requester response channels (valid/ready)
//   mem_req_*                    memory request channel, tag = {req_tag, idx}
//   mem_rsp_*                    memory response channel
//   busy                         any read outstanding
//   err                          sticky: response arrived with no read pending
module vx_mem_req_sched #(
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned ADDR_WIDTH   = 26,
  parameter int unsigned TAG_IN_WIDTH = 8,
  parameter int unsigned MAX_PENDING  = 16
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    req0_valid,
  input  logic                    req0_rw,
  input  logic [DATA_WIDTH/8-1:0] req0_byteen,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_data,
  input  logic [TAG_IN_WIDTH-1:0] req0_tag,
  output logic                    req0_ready,

  input  logic                    req1_valid,
  input  logic                    req1_rw,
  input  logic [DATA_WIDTH/8-1:0] req1_byteen,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_data,
  input  logic [TAG_IN_WIDTH-1:0] req1_tag,
  output logic                    req1_ready,

  output logic                    rsp0_valid,
  output logic [DATA_WIDTH-1:0]   rsp0_data,
  output logic [TAG_IN_WIDTH-1:0] rsp0_tag,
  input  logic                    rsp0_ready,

  output logic                    rsp1_valid,
  output logic [DATA_WIDTH-1:0]   rsp1_data,
  output logic [TAG_IN_WIDTH-1:0] rsp1_tag,
  input  logic                    rsp1_ready,

  output logic                    mem_req_valid,
  output logic                    mem_req_rw,
  output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_data,
  output logic [TAG_IN_WIDTH:0]   mem_req_tag,
  input  logic                    mem_req_ready,

  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
  input  logic [TAG_IN_WIDTH:0]   mem_rsp_tag,
  output logic                    mem_rsp_ready,

  output logic                    busy,
  output logic                    err
);

  localparam int unsigned CntW = $clog2(MAX_PENDING) + 1;
  typedef logic [CntW-1:0] cnt_t;

  logic rr_ptr_q, rr_ptr_d;
  logic lock_q, lock_d;
  logic lock_idx_q, lock_idx_d;
  logic err_q, err_d;
  cnt_t pend0_q, pend0_d;
  cnt_t pend1_q, pend1_d;

  logic elig0, elig1, grant, gnt_valid;
  logic rsp_sel, rsp_hs0, rsp_hs1, inc0, inc1;

  always_comb begin
    elig0 = req0_valid && !(!req0_rw && (pend0_q == cnt_t'(MAX_PENDING)));
    elig1 = req1_valid && !(!req1_rw && (pend1_q == cnt_t'(MAX_PENDING)));

    // A locked grant ignores the other requester even if it is eligible.
    grant = rr_ptr_q;
    if (lock_q)              grant = lock_idx_q;
    else if (elig0 && elig1) grant = rr_ptr_q;
    else if (elig0)          grant = 1'b0;
    else if (elig1)          grant = 1'b1;
    gnt_valid = grant ? elig1 : elig0;

    mem_req_valid  = gnt_valid && !reset;
    mem_req_rw     = grant ? req1_rw     : req0_rw;
    mem_req_byteen = grant ? req1_byteen : req0_byteen;
    mem_req_addr   = grant ? req1_addr   : req0_addr;
    mem_req_data   = grant ? req1_data   : req0_data;
    mem_req_tag    = {(grant ? req1_tag : req0_tag), grant};

    req0_ready = !reset && !grant && mem_req_ready && elig0;
    req1_ready = !reset &&  grant && mem_req_ready && elig1;
    inc0 = req0_ready && !req0_rw;
    inc1 = req1_ready && !req1_rw;

    rsp_sel       = mem_rsp_tag[0];
    rsp0_valid    = !reset && mem_rsp_valid && !rsp_sel;
    rsp1_valid    = !reset && mem_rsp_valid &&  rsp_sel;
    rsp0_data     = mem_rsp_data;
    rsp1_data     = mem_rsp_data;
    rsp0_tag      = mem_rsp_tag[TAG_IN_WIDTH:1];
    rsp1_tag      = mem_rsp_tag[TAG_IN_WIDTH:1];
    mem_rsp_ready = !reset && (rsp_sel ? rsp1_ready : rsp0_ready);
    rsp_hs0       = rsp0_valid && rsp0_ready;
    rsp_hs1       = rsp1_valid && rsp1_ready;

    busy = !reset && ((pend0_q != '0) || (pend1_q != '0));
    err  = !reset && err_q;
  end

  always_comb begin
    rr_ptr_d   = (mem_req_valid && mem_req_ready) ? ~grant : rr_ptr_q;
    // Lock only while a presented request is stalled; a dropped valid unlocks.
    lock_d     = mem_req_valid && !mem_req_ready;
    lock_idx_d = grant;
    // Unmatched responses flag an error and never wrap the counter.
    err_d   = err_q || (rsp_hs0 && (pend0_q == '0)) || (rsp_hs1 && (pend1_q == '0));
    pend0_d = pend0_q - cnt_t'(rsp_hs0 && (pend0_q != '0)) + cnt_t'(inc0);
    pend1_d = pend1_q - cnt_t'(rsp_hs1 && (pend1_q != '0)) + cnt_t'(inc1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= 1'b0;
      err_q      <= 1'b0;
      pend0_q    <= '0;
      pend1_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
      pend0_q    <= pend0_d;
      pend1_q    <= pend1_d;
    end
  end

endmodule
